// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one 16-bit serial transmitter between N_REQ requesters.
// A grant latches the winner's word, holds tx_start for TX_CYCLES cycles, then idles for
// GAP_CYCLES cycles before the next grant. All outputs are registered.
module tx_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned TX_CYCLES  = 24,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                       clk_115200hz,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [16*N_REQ-1:0]        req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       tx_start,
    output logic [0:15]                tx_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int unsigned IdW     = $clog2(N_REQ);
    localparam int unsigned CntMax  = (TX_CYCLES > GAP_CYCLES) ? TX_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW    = $clog2(CntMax) + 1;
    localparam int unsigned TxLoad  = TX_CYCLES - 1;
    // Guarded so the counter is never loaded with a wrapped negative value when the gap is 0.
    localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdW-1:0]      last_q, last_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                tx_start_q, tx_start_d;
    logic [15:0]         data_q, data_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [IdW-1:0]      win;
    logic [IdW-1:0]      cand;

    // Round-robin search starting just after the last served requester, with wrap-around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IdW'((int'(last_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ack_d      = '0;
        tx_start_d = tx_start_q;
        data_d     = data_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    data_d     = req_data[16*win +: 16];
                    ack_d[win] = 1'b1;
                    grant_d    = win;
                    last_d     = win;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = CntW'(TxLoad);
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (cnt_q == '0) begin
                    tx_start_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = CntW'(GapLoad);
                        state_d = StGap;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops tx_start immediately and forgets the frame.
    always_ff @(posedge clk_115200hz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= IdW'(N_REQ - 1);
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            data_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = data_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule
